// File: rtl/morse_rx_decoder.sv
// morse_rx_decoder
//   Recovers a Morse letter A..H from a keyed line. It measures the mark and
//   space lengths against a unit time, classifies each mark as a dot or a
//   dash, and at the end of the letter emits the same 0..7 letter code the
//   transmitter uses.
//
// Parameters
//   UNIT_CYCLES  length of one Morse unit in CLOCK_50 cycles (>= 4)
//   CNT_W        width of the mark/space duration counter
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   KEY0          in   asynchronous active-low reset
//   line_in       in   keyed line, 1 = mark, asynchronous to CLOCK_50
//   letter_code   out  last successfully decoded letter (A=0 .. H=7)
//   letter_valid  out  1-cycle pulse, letter_code updated this cycle
//   letter_err    out  1-cycle pulse, undecodable letter or line stuck high
//   busy          out  high while a letter is being received
module morse_rx_decoder #(
  parameter int UNIT_CYCLES = 16777216,
  parameter int CNT_W       = $clog2(5*UNIT_CYCLES+1)
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       line_in,
  output logic [2:0] letter_code,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX        = CNT_W'(5*UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HALF       = CNT_W'(UNIT_CYCLES/2);
  localparam logic [CNT_W-1:0] CNT_DASH       = CNT_W'(2*UNIT_CYCLES);
  // Terminating actions are registered on the edge where cnt reaches its
  // threshold, so they trigger while cnt still holds threshold-1.
  localparam logic [CNT_W-1:0] CNT_GAP_LAST   = CNT_W'(2*UNIT_CYCLES-1);
  localparam logic [CNT_W-1:0] CNT_STUCK_LAST = CNT_W'(5*UNIT_CYCLES-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_STUCK = 2'd3
  } state_t;

  logic [1:0]       sync_reg;
  logic             s;
  logic             s_prev_reg;
  logic             s_edge;
  logic             s_rise;
  logic             s_fall;
  logic [CNT_W-1:0] cnt_reg;

  state_t     state_reg, state_next;
  logic [3:0] pat_reg, pat_next;
  logic [2:0] ne_reg, ne_next;
  logic       ovf_reg, ovf_next;
  logic [2:0] code_reg, code_next;
  logic       valid_reg, valid_next;
  logic       err_reg, err_next;
  logic       busy_reg, busy_next;
  logic [3:0] dec;

  // {ok, code}: ok is 0 for any pattern that is not one of the eight letters.
  // Unused low bits of pat are always 0 because the buffer is cleared
  // between letters.
  function automatic logic [3:0] decode_fn(input logic [2:0] n, input logic [3:0] p);
    logic [3:0] r;
    r = 4'b0000;
    case ({n, p})
      {3'd2, 4'b0100}: r = 4'b1000; // A .-
      {3'd4, 4'b1000}: r = 4'b1001; // B -...
      {3'd4, 4'b1010}: r = 4'b1010; // C -.-.
      {3'd3, 4'b1000}: r = 4'b1011; // D -..
      {3'd1, 4'b0000}: r = 4'b1100; // E .
      {3'd4, 4'b0010}: r = 4'b1101; // F ..-.
      {3'd3, 4'b1100}: r = 4'b1110; // G --.
      {3'd4, 4'b0000}: r = 4'b1111; // H ....
      default:         r = 4'b0000;
    endcase
    return r;
  endfunction

  assign s      = sync_reg[1];
  assign s_edge = s ^ s_prev_reg;
  assign s_rise = s & ~s_prev_reg;
  assign s_fall = ~s & s_prev_reg;
  assign dec    = decode_fn(ne_reg, pat_reg);

  // Synchronizer, edge history and duration counter.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      sync_reg   <= 2'b00;
      s_prev_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync_reg   <= {sync_reg[0], line_in};
      s_prev_reg <= s;
      if (s_edge)
        cnt_reg <= CNT_W'(1);
      else if (cnt_reg < CNT_MAX)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_reg <= ST_IDLE;
      pat_reg   <= 4'b0000;
      ne_reg    <= 3'd0;
      ovf_reg   <= 1'b0;
      code_reg  <= 3'd0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      ne_reg    <= ne_next;
      ovf_reg   <= ovf_next;
      code_reg  <= code_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    ne_next    = ne_reg;
    ovf_next   = ovf_reg;
    code_next  = code_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      // Level test rather than edge: a mark that began in the same cycle a
      // letter terminated is picked up here one cycle later.
      ST_IDLE: begin
        if (s)
          state_next = ST_MARK;
      end

      ST_MARK: begin
        if (s_fall) begin
          if (cnt_reg < CNT_HALF) begin
            // Glitch: drop the mark, keep whatever elements we already have.
            state_next = (ne_reg != 3'd0) ? ST_SPACE : ST_IDLE;
          end else begin
            if (ne_reg == 3'd4) begin
              ovf_next = 1'b1;
            end else begin
              pat_next[2'd3 - ne_reg[1:0]] = (cnt_reg >= CNT_DASH);
              ne_next = ne_reg + 3'd1;
            end
            state_next = ST_SPACE;
          end
        end else if (cnt_reg >= CNT_STUCK_LAST) begin
          err_next   = 1'b1;
          pat_next   = 4'b0000;
          ne_next    = 3'd0;
          ovf_next   = 1'b0;
          state_next = ST_STUCK;
        end
      end

      ST_SPACE: begin
        // Letter termination wins over a mark starting in the same cycle.
        if (cnt_reg == CNT_GAP_LAST) begin
          if (dec[3] && !ovf_reg) begin
            valid_next = 1'b1;
            code_next  = dec[2:0];
          end else begin
            err_next = 1'b1;
          end
          pat_next   = 4'b0000;
          ne_next    = 3'd0;
          ovf_next   = 1'b0;
          state_next = ST_IDLE;
        end else if (s_rise) begin
          state_next = ST_MARK;
        end
      end

      ST_STUCK: begin
        if (!s)
          state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  assign letter_code  = code_reg;
  assign letter_valid = valid_reg;
  assign letter_err   = err_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// tb_morse_rx_decoder
//   Directed bench for morse_rx_decoder with an 8-cycle Morse unit. Inputs
//   change on the falling clock edge; a falling-edge monitor logs every
//   letter_valid / letter_err pulse, and each scenario checks the logged
//   counts, codes and cycle stamps against hand-computed values.
module tb_morse_rx_decoder;

  localparam int U = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_in = 1'b0;
  logic [2:0] letter_code;
  logic       letter_valid;
  logic       letter_err;
  logic       busy;

  morse_rx_decoder #(.UNIT_CYCLES(U)) dut (
    .CLOCK_50     (clk),
    .KEY0         (rst_n),
    .line_in      (line_in),
    .letter_code  (letter_code),
    .letter_valid (letter_valid),
    .letter_err   (letter_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  int n_valid        = 0;
  int n_err          = 0;
  int n_both         = 0;
  int last_valid_cyc = -1;
  int last_err_cyc   = -1;
  int busy_at_valid  = -1;
  int codes[$];

  always @(negedge clk) begin
    if (letter_valid) begin
      n_valid++;
      codes.push_back(int'(letter_code));
      last_valid_cyc = cyc;
      busy_at_valid  = int'(busy);
      $display("[TB] cyc %0d letter_valid code=%0d", cyc, letter_code);
    end
    if (letter_err) begin
      n_err++;
      last_err_cyc = cyc;
      $display("[TB] cyc %0d letter_err", cyc);
    end
    if (letter_valid && letter_err)
      n_both++;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic mark(input int n);
    line_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic space(input int n);
    line_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic int code_at(input int i);
    if (i < codes.size())
      return codes[i];
    return -1;
  endfunction

  int v0, e0, k, low_cyc;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_code",  int'(letter_code),  0);
    check("rst_valid", int'(letter_valid), 0);
    check("rst_err",   int'(letter_err),   0);
    check("rst_busy",  int'(busy),         0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Letter A with exact latency and busy timing
    v0 = n_valid; e0 = n_err;
    k = cyc;
    line_in = 1'b1;
    repeat (2) @(negedge clk);
    check("a_busy_before", int'(busy), 0);
    @(negedge clk);
    check("a_busy_rise", int'(busy), 1);
    repeat (5) @(negedge clk);
    space(8);
    mark(24);
    low_cyc = cyc + 1;
    space(30);
    check("a_nvalid", n_valid - v0, 1);
    check("a_code", code_at(v0), 0);
    check("a_latency", last_valid_cyc - low_cyc, 17);
    check("a_nerr", n_err - e0, 0);
    check("a_busy_at_pulse", busy_at_valid, 0);

    // H then C
    v0 = n_valid; e0 = n_err;
    mark(8); space(8); mark(8); space(8); mark(8); space(8); mark(8); space(24);
    mark(24); space(8); mark(8); space(8); mark(24); space(8); mark(8); space(24);
    check("hc_nvalid", n_valid - v0, 2);
    check("hc_code_h", code_at(v0), 7);
    check("hc_code_c", code_at(v0 + 1), 2);
    check("hc_nerr", n_err - e0, 0);

    // Reset in the middle of a letter
    mark(8); space(8); mark(8); space(4);
    check("mid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_code",  int'(letter_code),  0);
    check("mid_rst_busy",  int'(busy),         0);
    check("mid_rst_valid", int'(letter_valid), 0);
    check("mid_rst_err",   int'(letter_err),   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    v0 = n_valid; e0 = n_err;
    mark(8); space(24);
    check("e1_nvalid", n_valid - v0, 1);
    check("e1_code", code_at(v0), 4);
    check("e1_nerr", n_err - e0, 0);

    // Invalid: dash dash
    v0 = n_valid; e0 = n_err;
    mark(24); space(8); mark(24); space(24);
    check("mm_nerr", n_err - e0, 1);
    check("mm_nvalid", n_valid - v0, 0);
    check("mm_code_held", int'(letter_code), 4);

    // Invalid: five dots
    v0 = n_valid; e0 = n_err;
    mark(8); space(8); mark(8); space(8); mark(8); space(8); mark(8); space(8);
    mark(8); space(24);
    check("five_nerr", n_err - e0, 1);
    check("five_nvalid", n_valid - v0, 0);
    check("five_code_held", int'(letter_code), 4);

    // Glitch inside the gap of A
    v0 = n_valid; e0 = n_err;
    mark(8); space(2); mark(3); space(3); mark(24); space(24);
    check("gl_nvalid", n_valid - v0, 1);
    check("gl_code", code_at(v0), 0);
    check("gl_nerr", n_err - e0, 0);

    // Stuck high for 60 cycles
    v0 = n_valid; e0 = n_err;
    k = cyc;
    mark(60);
    check("stuck_nerr", n_err - e0, 1);
    check("stuck_nvalid", n_valid - v0, 0);
    check("stuck_time", ((last_err_cyc - k) >= 41 && (last_err_cyc - k) <= 42) ? 1 : 0, 1);
    check("stuck_busy", int'(busy), 1);
    space(24);
    check("stuck_after_nerr", n_err - e0, 1);
    check("stuck_after_nvalid", n_valid - v0, 0);
    check("stuck_after_busy", int'(busy), 0);

    // Clean E after the stuck line
    v0 = n_valid; e0 = n_err;
    mark(8); space(24);
    check("e2_nvalid", n_valid - v0, 1);
    check("e2_code", code_at(v0), 4);
    check("e2_nerr", n_err - e0, 0);

    check("never_both", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
